// File: rtl/midi_interface_adapter.sv
// MIDI 8N1 serial receiver and message assembler with running-status support.
// Optional macro MIDI_REALTIME_PASS_EN forwards real-time bytes (0xF8-0xFF) to MIDI_CMD.
module midi_interface_adapter #(
  parameter int D_W       = 16,
  parameter int BYTE_W    = 8,
  parameter int SYSCLK_F  = 48000000,
  parameter int MIDI_BAUD = 31250
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              MIDI_IN,
  output logic [BYTE_W-1:0] MIDI_CMD,
  output logic [BYTE_W-1:0] MIDI_DAT_0,
  output logic [BYTE_W-1:0] MIDI_DAT_1,
  output logic              CMD_READY,
  output logic              DATA_READY
);
  localparam int BIT_CLKS  = SYSCLK_F / MIDI_BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W     = $clog2(BIT_CLKS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CLKS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  if (BYTE_W != 8 || D_W < 1) begin : g_cfg_check
    $error("midi_interface_adapter: BYTE_W must be 8 and D_W positive");
  end

  // Number of data bytes a status byte introduces; 0 also covers SysEx.
  function automatic logic [1:0] msg_len(input logic [BYTE_W-1:0] st);
    case (st[7:4])
      4'hC, 4'hD: msg_len = 2'd1;
      4'hF: begin
        if (st == 8'hF1 || st == 8'hF3) msg_len = 2'd1;
        else if (st == 8'hF2)           msg_len = 2'd2;
        else                            msg_len = 2'd0;
      end
      default:    msg_len = 2'd2;
    endcase
  endfunction

  logic              sync_0, sync_1, rx_prev, rx, fall;
  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shift;
  logic              byte_vld;

  assign rx   = sync_1;
  assign fall = rx_prev & ~rx;

  // Stage 0: input synchronizer and falling-edge history
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_0  <= 1'b1;
      sync_1  <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync_0  <= MIDI_IN;
      sync_1  <= sync_0;
      rx_prev <= sync_1;
    end
  end

  // Stage 1: bit-centre sampling; byte_vld marks a frame with a good stop bit
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      byte_vld <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (fall) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx ? S_IDLE : S_DATA;
          end else cnt <= cnt + 1'b1;
        end
        S_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shift   <= {rx, shift[BYTE_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else cnt <= cnt + 1'b1;
        end
        S_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx) begin
              byte_vld <= 1'b1;
              state    <= S_IDLE;
            end else state <= S_WAIT_HIGH;
          end else cnt <= cnt + 1'b1;
        end
        S_WAIT_HIGH: if (rx) state <= S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  logic [BYTE_W-1:0] held;
  logic [1:0]        need;
  logic              keep, half_done;

  // Stage 2: message parser; keep distinguishes channel running status from system common
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      MIDI_CMD   <= '0;
      MIDI_DAT_0 <= '0;
      MIDI_DAT_1 <= '0;
      CMD_READY  <= 1'b0;
      DATA_READY <= 1'b0;
      held       <= '0;
      need       <= 2'd0;
      keep       <= 1'b0;
      half_done  <= 1'b0;
    end else begin
      CMD_READY  <= 1'b0;
      DATA_READY <= 1'b0;
      if (byte_vld) begin
        if (shift[BYTE_W-1]) begin
          if (shift >= 8'hF8) begin
`ifdef MIDI_REALTIME_PASS_EN
            MIDI_CMD  <= shift;
            CMD_READY <= 1'b1;
`else
            MIDI_CMD  <= MIDI_CMD;
`endif
          end else begin
            MIDI_CMD  <= shift;
            CMD_READY <= 1'b1;
            need      <= msg_len(shift);
            keep      <= (shift < 8'hF0);
            half_done <= 1'b0;
          end
        end else if (need != 2'd0) begin
          if (need == 2'd2 && !half_done) begin
            held      <= shift;
            half_done <= 1'b1;
          end else begin
            DATA_READY <= 1'b1;
            half_done  <= 1'b0;
            if (need == 2'd2) begin
              MIDI_DAT_0 <= held;
              MIDI_DAT_1 <= shift;
            end else begin
              MIDI_DAT_0 <= shift;
              MIDI_DAT_1 <= '0;
            end
            if (!keep) need <= 2'd0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_midi_interface_adapter.sv
// Directed and randomized bench for midi_interface_adapter with a message-level reference model.
module tb_midi_interface_adapter;
  localparam int SYSF = 500000;
  localparam int BAUD = 31250;
  localparam int BIT  = SYSF / BAUD;
  localparam int HALF = BIT / 2;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       MIDI_IN = 1'b1;
  logic [7:0] MIDI_CMD, MIDI_DAT_0, MIDI_DAT_1;
  logic       CMD_READY, DATA_READY;

  midi_interface_adapter #(.D_W(16), .BYTE_W(8), .SYSCLK_F(SYSF), .MIDI_BAUD(BAUD)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .MIDI_IN(MIDI_IN),
    .MIDI_CMD(MIDI_CMD), .MIDI_DAT_0(MIDI_DAT_0), .MIDI_DAT_1(MIDI_DAT_1),
    .CMD_READY(CMD_READY), .DATA_READY(DATA_READY)
  );

  always #10 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // Events: {kind(0=cmd,1=data), byte_a, byte_b}
  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  time         cmd_t, t_start;

  always @(negedge sys_clk) begin
    if (rst_n && (CMD_READY || DATA_READY)) begin
      total++;
      assert (!(CMD_READY && DATA_READY)) else begin
        bad++;
        $error("FAIL strobe_overlap obs=1 exp=0");
      end
      if (CMD_READY) begin
        obs_q.push_back({1'b0, MIDI_CMD, 8'h00});
        cmd_t = $time;
      end
      if (DATA_READY) obs_q.push_back({1'b1, MIDI_DAT_0, MIDI_DAT_1});
    end
  end

  // Reference model: message lengths from the MIDI byte ranges, pending data in a queue.
  int         m_need;
  bit         m_keep;
  logic [7:0] m_pend[$];
  logic [7:0] m_cmd, m_d0, m_d1;

  task automatic model_reset();
    m_need = 0; m_keep = 0; m_pend.delete();
    m_cmd = 8'h00; m_d0 = 8'h00; m_d1 = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'hF8) begin
`ifdef MIDI_REALTIME_PASS_EN
      m_cmd = b;
      exp_q.push_back({1'b0, b, 8'h00});
`endif
    end else if (b >= 8'h80) begin
      m_cmd = b;
      exp_q.push_back({1'b0, b, 8'h00});
      m_pend.delete();
      if (b >= 8'hF0) begin
        m_keep = 0;
        m_need = (b == 8'hF1 || b == 8'hF3) ? 1 : (b == 8'hF2) ? 2 : 0;
      end else begin
        m_keep = 1;
        m_need = (b >= 8'hC0 && b <= 8'hDF) ? 1 : 2;
      end
    end else if (m_need > 0) begin
      m_pend.push_back(b);
      if (m_pend.size() == m_need) begin
        m_d0 = m_pend[0];
        m_d1 = (m_need == 2) ? m_pend[1] : 8'h00;
        exp_q.push_back({1'b1, m_d0, m_d1});
        m_pend.delete();
        if (!m_keep) m_need = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    MIDI_IN = 1'b0;
    t_start = $time;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      MIDI_IN = b[i];
      wait_clks(BIT);
    end
    MIDI_IN = stop_ok;
    wait_clks(BIT);
    MIDI_IN = 1'b1;
    if (stop_ok) model_byte(b);
    else wait_clks(BIT);
  endtask

  task automatic check_events(input string tag);
    wait_clks(BIT);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    chk({tag, "_cmd"}, 32'(MIDI_CMD), 32'(m_cmd));
    chk({tag, "_dat0"}, 32'(MIDI_DAT_0), 32'(m_d0));
    chk({tag, "_dat1"}, 32'(MIDI_DAT_1), 32'(m_d1));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    MIDI_IN = 1'b1;
    wait_clks(3);
    model_reset();
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    time        t_c9;
    logic [7:0] b;
    int         sel;
    model_reset();
    do_reset();

    // Idle line after reset
    wait_clks(3 * BIT);
    chk("idle_strobes", {30'd0, CMD_READY, DATA_READY}, 32'd0);
    check_events("idle");

    // Program change with running status
    send_frame(8'hC9, 1);
    t_c9 = t_start;
    send_frame(8'h7E, 1);
    send_frame(8'h55, 1);
    chk("c9_latency_ok",
        32'(((cmd_t - t_c9) / 20 >= HALF + 9 * BIT) && ((cmd_t - t_c9) / 20 <= HALF + 9 * BIT + 6)),
        32'd1);
    check_events("c9_run");

    send_frame(8'h90, 1); send_frame(8'h3C, 1); send_frame(8'h64, 1);
    check_events("note_on");

    send_frame(8'h90, 1); send_frame(8'h3C, 1); send_frame(8'hF8, 1); send_frame(8'h64, 1);
    check_events("realtime_mid");

    // Orphan data byte and framing error
    do_reset();
    send_frame(8'h40, 1);
    check_events("orphan");
    send_frame(8'h91, 0);
    send_frame(8'hE2, 1); send_frame(8'h10, 1); send_frame(8'h20, 1);
    check_events("framing");

    // Short low glitch
    MIDI_IN = 1'b0;
    wait_clks(5);
    MIDI_IN = 1'b1;
    wait_clks(2 * BIT);
    check_events("glitch");

    // Reset in the middle of a frame
    MIDI_IN = 1'b0;
    wait_clks(3 * BIT);
    do_reset();
    wait_clks(2 * BIT);
    check_events("midreset");
    send_frame(8'hD3, 1); send_frame(8'h11, 1);
    check_events("after_reset");

    // System common and SysEx
    send_frame(8'hF2, 1); send_frame(8'h01, 1); send_frame(8'h02, 1); send_frame(8'h03, 1);
    send_frame(8'hF0, 1); send_frame(8'h12, 1); send_frame(8'hF7, 1); send_frame(8'h13, 1);
    check_events("syscommon");

    // Randomized byte stream
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)       b = 8'(8'h80 + $urandom_range(0, 8'h6F));
      else if (sel == 2) b = 8'(8'hF0 + $urandom_range(0, 7));
      else if (sel == 3) b = 8'(8'hF8 + $urandom_range(0, 7));
      else               b = 8'($urandom_range(0, 8'h7F));
      send_frame(b, $urandom_range(0, 11) != 0);
      if (n % 10 == 9) check_events("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
